// File: rtl/cpu_debug_dump_pkg.sv
// Shared definitions for the post-halt debug dump block: FSM state codes,
// frame delimiters, frame length helper and the snapshot payload struct.
package cpu_debug_dump_pkg;

    localparam int unsigned ST_W = 4;

    // FSM state codes
    localparam logic [ST_W-1:0] ST_IDLE    = 4'd0;
    localparam logic [ST_W-1:0] ST_HDR     = 4'd1;
    localparam logic [ST_W-1:0] ST_PC_H    = 4'd2;
    localparam logic [ST_W-1:0] ST_PC_L    = 4'd3;
    localparam logic [ST_W-1:0] ST_CYC_H   = 4'd4;
    localparam logic [ST_W-1:0] ST_CYC_L   = 4'd5;
    localparam logic [ST_W-1:0] ST_RD_REQ  = 4'd6;
    localparam logic [ST_W-1:0] ST_RD_WAIT = 4'd7;
    localparam logic [ST_W-1:0] ST_W_H     = 4'd8;
    localparam logic [ST_W-1:0] ST_W_L     = 4'd9;
    localparam logic [ST_W-1:0] ST_TRL     = 4'd10;
    localparam logic [ST_W-1:0] ST_DONE    = 4'd11;

    localparam logic [7:0] FRAME_SOF = 8'hA5;
    localparam logic [7:0] FRAME_EOF = 8'h5A;

    // Header (SOF, PC x2, CYC x2) plus trailer
    localparam int unsigned FRAME_FIXED_BYTES = 6;

    // Snapshot taken on the halt edge; both fields are sent MSB first
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] cyc;
    } snap_t;

    function automatic int unsigned frame_len(input int unsigned words);
        return FRAME_FIXED_BYTES + 2 * words;
    endfunction

    // States that present a byte on the transmit interface
    function automatic logic is_byte_state(input logic [ST_W-1:0] st);
        return (st == ST_HDR)   || (st == ST_PC_H)  || (st == ST_PC_L) ||
               (st == ST_CYC_H) || (st == ST_CYC_L) || (st == ST_W_H)  ||
               (st == ST_W_L)   || (st == ST_TRL);
    endfunction

endpackage

// File: rtl/cpu_debug_dump_counter.sv
// dbg_cycle_counter: saturating up-counter with synchronous clear.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_en     count enable (+1 per edge, holds at all-ones)
//   i_clr    synchronous clear, wins over i_en
//   o_count  registered count value
module dbg_cycle_counter #(
    parameter int unsigned NBITS_CNT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic                 i_clr,
    output logic [NBITS_CNT-1:0] o_count
);

    logic [NBITS_CNT-1:0] cnt_q;
    logic [NBITS_CNT-1:0] cnt_d;

    // Next count: clear, else saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + NBITS_CNT'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;

endmodule

// File: rtl/cpu_debug_dump.sv
// cpu_debug_dump: after the core halts, snapshot PC and the execution cycle
// count, read the first DUMP_WORDS data-memory words and stream a framed
// byte sequence over a valid/ready byte interface.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_Halt, i_PmAddr            core halt flag and PC
//   o_DmSel, o_DmRd, o_DmAddr   borrowed data-memory read port (request side)
//   i_DmData                    read data, valid the cycle after o_DmRd
//   o_TxData, o_TxValid         byte stream out
//   i_TxReady                   consumer accepts the presented byte
//   o_Busy, o_Done              frame in progress / end-of-frame pulse
// All outputs are registered and computed from the next-state values.
module cpu_debug_dump
    import cpu_debug_dump_pkg::*;
#(
    parameter int unsigned NBITS_O    = 11,
    parameter int unsigned NBITS_D    = 16,
    parameter int unsigned NBITS_CNT  = 16,
    parameter int unsigned DUMP_WORDS = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_Halt,
    input  logic [NBITS_O-1:0] i_PmAddr,
    output logic               o_DmSel,
    output logic               o_DmRd,
    output logic [NBITS_O-1:0] o_DmAddr,
    input  logic [NBITS_D-1:0] i_DmData,
    output logic [7:0]         o_TxData,
    output logic               o_TxValid,
    input  logic               i_TxReady,
    output logic               o_Busy,
    output logic               o_Done
);

    localparam logic [NBITS_O-1:0] LAST_IDX = NBITS_O'(DUMP_WORDS - 1);

    logic [ST_W-1:0]    state_q, state_d;
    logic               halt_q;
    logic [NBITS_O-1:0] idx_q, idx_d;
    snap_t              snap_q, snap_d;
    logic [15:0]        word_q, word_d;

    logic               dm_sel_q, dm_sel_d;
    logic               dm_rd_q, dm_rd_d;
    logic [NBITS_O-1:0] dm_addr_q, dm_addr_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NBITS_CNT-1:0] cnt;
    logic                 cnt_en;
    logic                 cnt_clr;
    logic                 accept;
    logic                 halt_rise;

    assign accept    = tx_valid_q & i_TxReady;
    assign halt_rise = i_Halt & ~halt_q;

    // Count only while the core runs and no frame is active; reset on frame end
    assign cnt_en  = (state_q == ST_IDLE) & ~i_Halt;
    assign cnt_clr = (state_q == ST_DONE);

    dbg_cycle_counter #(
        .NBITS_CNT (NBITS_CNT)
    ) u_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (cnt_en),
        .i_clr   (cnt_clr),
        .o_count (cnt)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE: begin
                if (halt_rise) begin
                    state_d    = ST_HDR;
                    snap_d.pc  = 16'(i_PmAddr);
                    snap_d.cyc = 16'(cnt);
                    idx_d      = '0;
                end
            end
            ST_HDR:     if (accept) state_d = ST_PC_H;
            ST_PC_H:    if (accept) state_d = ST_PC_L;
            ST_PC_L:    if (accept) state_d = ST_CYC_H;
            ST_CYC_H:   if (accept) state_d = ST_CYC_L;
            ST_CYC_L:   if (accept) state_d = ST_RD_REQ;
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                word_d  = 16'(i_DmData);
                state_d = ST_W_H;
            end
            ST_W_H:     if (accept) state_d = ST_W_L;
            ST_W_L: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_TRL;
                    end else begin
                        idx_d   = idx_q + NBITS_O'(1);
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_TRL:     if (accept) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode from next-state values so the registered outputs line
    // up with the state they describe; data holds while a byte is stalled
    always_comb begin
        tx_valid_d = is_byte_state(state_d);
        tx_data_d  = 8'h00;
        case (state_d)
            ST_HDR:   tx_data_d = FRAME_SOF;
            ST_PC_H:  tx_data_d = snap_d.pc[15:8];
            ST_PC_L:  tx_data_d = snap_d.pc[7:0];
            ST_CYC_H: tx_data_d = snap_d.cyc[15:8];
            ST_CYC_L: tx_data_d = snap_d.cyc[7:0];
            ST_W_H:   tx_data_d = word_d[15:8];
            ST_W_L:   tx_data_d = word_d[7:0];
            ST_TRL:   tx_data_d = FRAME_EOF;
            default:  tx_data_d = 8'h00;
        endcase
        dm_rd_d   = (state_d == ST_RD_REQ);
        dm_addr_d = dm_rd_d ? idx_d : '0;
        dm_sel_d  = (state_d == ST_RD_REQ) || (state_d == ST_RD_WAIT) ||
                    (state_d == ST_W_H)    || (state_d == ST_W_L);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            halt_q     <= 1'b0;
            idx_q      <= '0;
            snap_q     <= '0;
            word_q     <= '0;
            dm_sel_q   <= 1'b0;
            dm_rd_q    <= 1'b0;
            dm_addr_q  <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            halt_q     <= i_Halt;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            word_q     <= word_d;
            dm_sel_q   <= dm_sel_d;
            dm_rd_q    <= dm_rd_d;
            dm_addr_q  <= dm_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_DmSel   = dm_sel_q;
    assign o_DmRd    = dm_rd_q;
    assign o_DmAddr  = dm_addr_q;
    assign o_TxData  = tx_data_q;
    assign o_TxValid = tx_valid_q;
    assign o_Busy    = busy_q;
    assign o_Done    = done_q;

endmodule
